// File: rtl/core_icache_pkg.sv
// Shared types and constants for the I-cache AXI refill path.
package core_icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_DONE,
        ST_DRAIN
    } refill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int refill_beats(input int line_width, input int bus_width);
        return line_width / bus_width;
    endfunction

    // AxSIZE encoding: log2 of bytes per beat
    function automatic int refill_arsize(input int bus_width);
        return $clog2(bus_width / 8);
    endfunction

endpackage

// File: rtl/core_icache_line_assembler.sv
// Collects R-channel beats into one cache line; slot index wraps from a start slot.
module core_icache_line_assembler #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4,
    parameter int CNT_W      = 2
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  clear,
    input  logic [CNT_W-1:0]      start_slot,
    input  logic                  beat_valid,
    input  logic [BEAT_WIDTH-1:0] beat_data,
    output logic                  last_beat,
    output logic [LINE_WIDTH-1:0] line
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] slot_idx;

    // BEATS is a power of two, so CNT_W-bit addition gives the mod-BEATS wrap
    assign slot_idx  = start_slot + cnt_reg;
    assign last_beat = (cnt_reg == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (beat_valid) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [BEAT_WIDTH-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    data_reg <= '0;
                end else if (beat_valid && (slot_idx == CNT_W'(gi))) begin
                    data_reg <= beat_data;
                end
            end

            assign line[gi*BEAT_WIDTH +: BEAT_WIDTH] = data_reg;
        end
    endgenerate

endmodule

// File: rtl/core_icache_axi_refill.sv
// I-cache line refill over one AXI4 read burst. Define ICACHE_REFILL_WRAP_EN for
// critical-word-first (WRAP burst); otherwise an aligned INCR burst is issued.
module core_icache_axi_refill
    import core_icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr_from_control_to_axi,
    output logic                      o_mem_done,
    output logic [AXI_DATA_WIDTH-1:0] o_block_from_axi,
    output logic                      o_refill_err,
    output logic [AXI_ID_WIDTH-1:0]   o_arid,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [AXI_ID_WIDTH-1:0]   i_rid,
    input  logic [BUS_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready
);

    localparam int BEATS    = refill_beats(AXI_DATA_WIDTH, BUS_DATA_WIDTH);
    localparam int CNT_W    = $clog2(BEATS);
    localparam int BEAT_OFF = refill_arsize(BUS_DATA_WIDTH);

    refill_state_t state_reg, state_next;

    logic [AXI_ID_WIDTH-1:0] arid_reg;
    logic [ADDR_WIDTH-1:0]   araddr_reg;
    logic [7:0]              arlen_reg;
    logic [2:0]              arsize_reg;
    logic [1:0]              arburst_reg;
    logic [CNT_W-1:0]        start_reg;
    logic                    err_reg;

    logic [ADDR_WIDTH-1:0]   araddr_next;
    logic [1:0]              arburst_next;
    logic [CNT_W-1:0]        start_next;
    logic                    accept;
    logic                    beat_fire;
    logic                    last_beat;
    logic                    beat_err;
    logic                    unused_rid;

    // Read IDs are not checked: only one burst is ever outstanding
    assign unused_rid = ^i_rid;

`ifdef ICACHE_REFILL_WRAP_EN
    localparam logic [ADDR_WIDTH-1:0] BEAT_ALIGN =
        ~((ADDR_WIDTH'(1) << BEAT_OFF) - ADDR_WIDTH'(1));
    assign araddr_next  = i_addr_from_control_to_axi & BEAT_ALIGN;
    assign arburst_next = AXI_BURST_WRAP;
    assign start_next   = i_addr_from_control_to_axi[BEAT_OFF+CNT_W-1:BEAT_OFF];
`else
    localparam logic [ADDR_WIDTH-1:0] LINE_ALIGN =
        ~((ADDR_WIDTH'(1) << (BEAT_OFF + CNT_W)) - ADDR_WIDTH'(1));
    assign araddr_next  = i_addr_from_control_to_axi & LINE_ALIGN;
    assign arburst_next = AXI_BURST_INCR;
    assign start_next   = '0;
`endif

    assign accept    = (state_reg == ST_IDLE) && i_mem_req;
    assign beat_fire = (state_reg == ST_R) && i_rvalid;
    // RLAST must appear on exactly the final beat
    assign beat_err  = (i_rresp != AXI_RESP_OKAY) || (i_rlast != last_beat);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (i_mem_req) state_next = ST_AR;
            ST_AR:    if (i_arready) state_next = ST_R;
            ST_R:     if (i_rvalid && last_beat) state_next = ST_DONE;
            ST_DONE:  state_next = i_mem_req ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (!i_mem_req) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            arid_reg    <= '0;
            araddr_reg  <= '0;
            arlen_reg   <= '0;
            arsize_reg  <= '0;
            arburst_reg <= '0;
            start_reg   <= '0;
            err_reg     <= 1'b0;
        end else if (accept) begin
            arid_reg    <= AXI_ID_WIDTH'(AXI_ID);
            araddr_reg  <= araddr_next;
            arlen_reg   <= 8'(BEATS - 1);
            arsize_reg  <= 3'(BEAT_OFF);
            arburst_reg <= arburst_next;
            start_reg   <= start_next;
            err_reg     <= 1'b0;
        end else if (beat_fire && beat_err) begin
            err_reg     <= 1'b1;
        end
    end

    core_icache_line_assembler #(
        .LINE_WIDTH (AXI_DATA_WIDTH),
        .BEAT_WIDTH (BUS_DATA_WIDTH),
        .BEATS      (BEATS),
        .CNT_W      (CNT_W)
    ) u_line_assembler (
        .clk        (i_clk),
        .srst       (i_rst),
        .clear      (accept),
        .start_slot (start_reg),
        .beat_valid (beat_fire),
        .beat_data  (i_rdata),
        .last_beat  (last_beat),
        .line       (o_block_from_axi)
    );

    assign o_arid       = arid_reg;
    assign o_araddr     = araddr_reg;
    assign o_arlen      = arlen_reg;
    assign o_arsize     = arsize_reg;
    assign o_arburst    = arburst_reg;
    assign o_arvalid    = (state_reg == ST_AR);
    assign o_rready     = (state_reg == ST_R);
    assign o_mem_done   = (state_reg == ST_DONE);
    assign o_refill_err = (state_reg == ST_DONE) && err_reg;

endmodule

// File: tb/tb_core_icache_axi_refill.sv
// Self-checking bench for core_icache_axi_refill: directed table, reset corner case, random refills.
module tb_core_icache_axi_refill;

`ifdef ICACHE_REFILL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req;
    logic [63:0]  addr;
    logic         mem_done;
    logic [255:0] block;
    logic         refill_err;
    logic [3:0]   arid;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_icache_axi_refill dut (
        .i_clk                      (clk),
        .i_rst                      (rst),
        .i_mem_req                  (mem_req),
        .i_addr_from_control_to_axi (addr),
        .o_mem_done                 (mem_done),
        .o_block_from_axi           (block),
        .o_refill_err               (refill_err),
        .o_arid                     (arid),
        .o_araddr                   (araddr),
        .o_arlen                    (arlen),
        .o_arsize                   (arsize),
        .o_arburst                  (arburst),
        .o_arvalid                  (arvalid),
        .i_arready                  (arready),
        .i_rid                      (rid),
        .i_rdata                    (rdata),
        .i_rresp                    (rresp),
        .i_rlast                    (rlast),
        .i_rvalid                   (rvalid),
        .o_rready                   (rready)
    );

    typedef struct {
        logic [63:0]  addr;
        int           ar_dly;
        int           max_gap;
        logic [7:0]   resp_bits;   // 2 bits per beat, beat k at [2k+1:2k]
        logic [3:0]   rlast_bits;  // bit k = RLAST on beat k
        logic [255:0] data;        // beat k (arrival order) at [64k+63:64k]
        int           hold;        // cycles i_mem_req stays high after done
        logic         exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Line layout: slot j holds bytes 8j..8j+7; the burst starts at the missed word when wrapping
    function automatic logic [255:0] model_line(input logic [63:0] a, input logic [255:0] beats);
        logic [255:0] l;
        int start;
        l = '0;
        start = WRAP ? int'(a[4:3]) : 0;
        for (int k = 0; k < 4; k++) l[((start + k) % 4) * 64 +: 64] = beats[k*64 +: 64];
        return l;
    endfunction

    function automatic logic [63:0] model_araddr(input logic [63:0] a);
        return WRAP ? (a / 8) * 8 : (a / 32) * 32;
    endfunction

    task automatic run_refill(input vec_t v, input string tag);
        logic [255:0] exp_line;
        logic [63:0]  exp_addr;
        int           waited;
        int           gap;
        exp_line = model_line(v.addr, v.data);
        exp_addr = model_araddr(v.addr);
        @(negedge clk);
        mem_req = 1'b1;
        addr    = v.addr;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!arvalid && waited < 20);
        chk({tag, " ar_latency"}, 256'(waited), 256'd1);
        if (!arvalid) begin
            mem_req = 1'b0;
            return;
        end
        chk({tag, " araddr"}, araddr, exp_addr);
        chk({tag, " arlen"}, arlen, 8'd3);
        chk({tag, " arsize"}, arsize, 3'd3);
        chk({tag, " arburst"}, arburst, WRAP ? 2'b10 : 2'b01);
        chk({tag, " arid"}, arid, 4'd0);
        for (int i = 0; i < v.ar_dly; i++) begin
            @(negedge clk);
            chk({tag, " ar_hold_valid"}, arvalid, 1'b1);
            chk({tag, " ar_hold_addr"}, araddr, exp_addr);
            chk({tag, " ar_hold_len"}, arlen, 8'd3);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk({tag, " ar_drop"}, arvalid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            gap = (v.max_gap > 0) ? $urandom_range(0, v.max_gap) : 0;
            for (int g = 0; g < gap; g++) begin
                chk({tag, " gap_no_done"}, mem_done, 1'b0);
                @(negedge clk);
            end
            chk({tag, " rready"}, rready, 1'b1);
            rvalid = 1'b1;
            rdata  = v.data[k*64 +: 64];
            rresp  = v.resp_bits[k*2 +: 2];
            rlast  = v.rlast_bits[k];
            @(negedge clk);
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            if (k < 3) chk({tag, " early_done"}, mem_done, 1'b0);
        end
        chk({tag, " done"}, mem_done, 1'b1);
        chk({tag, " err"}, refill_err, v.exp_err);
        chk({tag, " line"}, block, exp_line);
        if (v.hold == 0) mem_req = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({tag, " drain_no_ar"}, arvalid, 1'b0);
            chk({tag, " drain_no_done"}, mem_done, 1'b0);
            if (h == v.hold - 1) mem_req = 1'b0;
        end
        @(negedge clk);
        chk({tag, " done_pulse"}, mem_done, 1'b0);
        chk({tag, " line_stable"}, block, exp_line);
        @(negedge clk);
        chk({tag, " idle_no_ar"}, arvalid, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " arvalid"}, arvalid, 1'b0);
        chk({tag, " rready"}, rready, 1'b0);
        chk({tag, " mem_done"}, mem_done, 1'b0);
        chk({tag, " refill_err"}, refill_err, 1'b0);
        chk({tag, " block"}, block, 256'd0);
        chk({tag, " araddr"}, araddr, 64'd0);
        chk({tag, " arlen"}, arlen, 8'd0);
        chk({tag, " arsize"}, arsize, 3'd0);
        chk({tag, " arburst"}, arburst, 2'd0);
        chk({tag, " arid"}, arid, 4'd0);
    endtask

    vec_t table_v[7];
    vec_t rv;
    int   waited;

    initial begin
        rst = 1'b1; mem_req = 1'b0; addr = '0; arready = 1'b0;
        rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        table_v[0] = '{64'h0000_0000_8000_1234, 0, 0, 8'h00, 4'b1000,
                       {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                        64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}, 0, 1'b0};
        table_v[1] = '{64'h0000_0000_4000_0040, 5, 3, 8'h00, 4'b1000,
                       {64'h4444_AAAA_0000_0004, 64'h3333_AAAA_0000_0003,
                        64'h2222_AAAA_0000_0002, 64'h1111_AAAA_0000_0001}, 0, 1'b0};
        table_v[2] = '{64'h0000_0000_0000_1018, 0, 1, 8'h00, 4'b1000,
                       {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                        64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0}, 0, 1'b0};
        table_v[3] = '{64'h0000_0000_0000_2000, 1, 0, 8'b00_10_00_00, 4'b1000,
                       {64'h5, 64'h6, 64'h7, 64'h8}, 0, 1'b1};
        table_v[4] = '{64'h0000_0000_0000_3008, 0, 2, 8'h00, 4'b0100,
                       {64'h9, 64'hA, 64'hB, 64'hC}, 0, 1'b1};
        table_v[5] = '{64'h0000_0000_0000_4010, 2, 0, 8'h00, 4'b1000,
                       {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000}, 3, 1'b0};
        table_v[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 8'h00, 4'b1000,
                       {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1, 1'b0};

        for (int i = 0; i < 7; i++) run_refill(table_v[i], $sformatf("vec%0d", i));

        // Reset during the R phase after two beats
        @(negedge clk);
        mem_req = 1'b1;
        addr    = 64'h0000_0000_2000_0100;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!arvalid && waited < 20);
        chk("rst_mid ar_seen", arvalid, 1'b1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rvalid = 1'b1;
            rdata  = {$urandom(), $urandom()};
            rlast  = 1'b0;
            @(negedge clk);
            rvalid = 1'b0;
        end
        rst = 1'b1;
        mem_req = 1'b0;
        @(negedge clk);
        chk_reset_state("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid no_done", mem_done, 1'b0);
        run_refill('{64'h0000_0000_2000_0108, 1, 1, 8'h00, 4'b1000,
                     {64'h77, 64'h66, 64'h55, 64'h44}, 0, 1'b0}, "post_rst");

        for (int n = 0; n < 25; n++) begin
            rv.addr       = {$urandom(), $urandom()};
            rv.ar_dly     = $urandom_range(0, 4);
            rv.max_gap    = $urandom_range(0, 3);
            rv.resp_bits  = 8'h00;
            if ($urandom_range(0, 4) == 0)
                rv.resp_bits[2 * $urandom_range(0, 3) +: 2] = 2'($urandom_range(1, 3));
            rv.rlast_bits = 4'b1000;
            if ($urandom_range(0, 5) == 0) rv.rlast_bits = 4'($urandom_range(0, 15));
            for (int j = 0; j < 8; j++) rv.data[j*32 +: 32] = $urandom();
            rv.hold       = $urandom_range(0, 2);
            rv.exp_err    = (rv.resp_bits != 8'h00) || (rv.rlast_bits != 4'b1000);
            run_refill(rv, $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
